// File: rtl/fpa_pkg.sv
// Shared types and default widths for the FP adder alignment pipeline.
package fpa_pkg;

  localparam int unsigned DEF_MANT_W = 54;
  localparam int unsigned DEF_EXP_W  = 11;
  localparam int unsigned GRS_W      = 3;

  // Stage-1 to stage-2 payload: operands already ordered by exponent.
  typedef struct packed {
    logic [DEF_MANT_W-1:0] big_mant;
    logic [DEF_MANT_W-1:0] small_mant;
    logic [DEF_EXP_W-1:0]  exp;
    logic [DEF_EXP_W-1:0]  diff;
    logic                  swap;
  } s1_payload_t;

endpackage

// File: rtl/sticky_rshift.sv
// Combinational right shift of the smaller mantissa with guard/round/sticky
// extraction; shift amounts beyond the extended width saturate to all-sticky.
module sticky_rshift
  import fpa_pkg::*;
#(
  parameter int unsigned MANT_W = DEF_MANT_W,
  parameter int unsigned EXP_W  = DEF_EXP_W
) (
  input  logic [MANT_W-1:0] small_mant_i,
  input  logic [EXP_W-1:0]  diff_i,
  output logic [MANT_W-1:0] aligned_mant_c_o,
  output logic [GRS_W-1:0]  grs_c_o
);

  localparam int unsigned EXT_W = MANT_W + 2;

  logic [EXT_W-1:0] ext_c;
  logic [EXT_W-1:0] shifted_c;
  logic [EXT_W-1:0] lost_mask_c;
  logic             sat_c;

  always_comb begin
    ext_c       = {small_mant_i, 2'b00};
    sat_c       = (32'(diff_i) >= EXT_W);
    shifted_c   = ext_c >> diff_i;
    // Bits of ext below position diff are the ones pushed past the round bit.
    lost_mask_c = ~({EXT_W{1'b1}} << diff_i);
    aligned_mant_c_o = '0;
    grs_c_o          = '0;
    if (sat_c) begin
      aligned_mant_c_o = '0;
      grs_c_o          = {2'b00, |small_mant_i};
    end else begin
      aligned_mant_c_o = shifted_c[EXT_W-1:2];
      grs_c_o          = {shifted_c[1:0], |(ext_c & lost_mask_c)};
    end
  end

endmodule

// File: rtl/align_shift_pipe.sv
// Two-stage exponent alignment: order operands by exponent, then right-shift
// the smaller mantissa with GRS capture, under valid/ready flow control.
module align_shift_pipe
  import fpa_pkg::*;
#(
  parameter int unsigned MANT_W = DEF_MANT_W,
  parameter int unsigned EXP_W  = DEF_EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_big_mant,
  input  logic [MANT_W-1:0] in_small_mant,
  input  logic [EXP_W-1:0]  in_big_exp,
  input  logic [EXP_W-1:0]  in_small_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_big_mant,
  output logic [MANT_W-1:0] out_small_mant,
  output logic [GRS_W-1:0]  out_grs,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_swapped
);

  logic              s1_valid_q, s1_valid_d;
  s1_payload_t       s1_q, s1_d;

  logic              s2_valid_q, s2_valid_d;
  logic [MANT_W-1:0] s2_big_q, s2_big_d;
  logic [MANT_W-1:0] s2_small_q, s2_small_d;
  logic [GRS_W-1:0]  s2_grs_q, s2_grs_d;
  logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
  logic              s2_swap_q, s2_swap_d;

  logic              ready_s1_c, ready_s2_c;
  logic              swap_c;
  logic [EXP_W-1:0]  exp_max_c, exp_min_c;
  logic [MANT_W-1:0] sh_mant_c;
  logic [GRS_W-1:0]  sh_grs_c;

  // A stage can load when empty or when its contents leave this cycle.
  assign ready_s2_c = !s2_valid_q || out_ready;
  assign ready_s1_c = !s1_valid_q || ready_s2_c;
  assign in_ready   = ready_s1_c;

  assign swap_c    = (in_small_exp > in_big_exp);
  assign exp_max_c = swap_c ? in_small_exp : in_big_exp;
  assign exp_min_c = swap_c ? in_big_exp   : in_small_exp;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (ready_s1_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.swap       = swap_c;
        s1_d.big_mant   = swap_c ? in_small_mant : in_big_mant;
        s1_d.small_mant = swap_c ? in_big_mant   : in_small_mant;
        s1_d.exp        = exp_max_c;
        s1_d.diff       = exp_max_c - exp_min_c;
      end
    end
  end

  sticky_rshift #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_sticky_rshift (
    .small_mant_i     (s1_q.small_mant),
    .diff_i           (s1_q.diff),
    .aligned_mant_c_o (sh_mant_c),
    .grs_c_o          (sh_grs_c)
  );

  // Data only moves with a valid token so the outputs hold the last result.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_big_d   = s2_big_q;
    s2_small_d = s2_small_q;
    s2_grs_d   = s2_grs_q;
    s2_exp_d   = s2_exp_q;
    s2_swap_d  = s2_swap_q;
    if (ready_s2_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_big_d   = s1_q.big_mant;
        s2_small_d = sh_mant_c;
        s2_grs_d   = sh_grs_c;
        s2_exp_d   = s1_q.exp;
        s2_swap_d  = s1_q.swap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_big_q   <= '0;
      s2_small_q <= '0;
      s2_grs_q   <= '0;
      s2_exp_q   <= '0;
      s2_swap_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_big_q   <= s2_big_d;
      s2_small_q <= s2_small_d;
      s2_grs_q   <= s2_grs_d;
      s2_exp_q   <= s2_exp_d;
      s2_swap_q  <= s2_swap_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_big_mant   = s2_big_q;
  assign out_small_mant = s2_small_q;
  assign out_grs        = s2_grs_q;
  assign out_exp        = s2_exp_q;
  assign out_swapped    = s2_swap_q;

endmodule
